rr_priority_encoder: RTL and testbench
======================================

Name: rr_priority_encoder

Overview:
- Parametrised, registered N-input priority encoder with a selectable fixed-priority or round-robin mode.
- Latches the winning request index into a valid/ready output stage and holds it until the consumer accepts it.
- Successor to the team's 4-input combinational encoder. That encoder's index/valid semantics are kept: highest index wins, and "any" is the OR of all requests. This block adds width generalisation, a rotating-priority mode and a handshake.
- Sits between request sources and a single shared resource or consumer.

Parameters:
- N, 8, number of request lines; legal range 2..64.
- IDX_W, clog2(N), width of the index output; derived localparam, not overridable.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  level request vector; bit i set means requester i is pending.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- out_ready  input  1  consumer accepts the held grant when high together with out_valid.
- out_valid  output  1  a grant is held on idx/onehot.
- idx  output  IDX_W  binary index of the granted requester.
- onehot  output  N  one-hot form of idx; all zero when out_valid=0.
- any  output  1  combinational OR of req; same as the reference v output.

Behaviour:
- Reset: one cycle of rst=1 forces:
  - state=IDLE, out_valid=0, idx=0, onehot=0;
  - round-robin pointer ptr=0.
  - any stays combinational and tracks req during reset.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - If req!=0 at a rising edge, compute the winner, register idx and onehot, set out_valid=1 and go to HOLD.
  - Otherwise stay in IDLE with outputs at 0.
  - Latency: req sampled at edge t gives out_valid=1 after edge t.
- HOLD:
  - idx, onehot and out_valid are frozen regardless of changes on req or mode.
  - If out_valid and out_ready at an edge, the grant is accepted:
    - out_valid=0 and onehot=0; idx keeps its last value.
    - ptr<=idx.
    - Return to IDLE.
  - Otherwise stay in HOLD.
  - Exactly one bubble cycle follows every accept. Maximum throughput is one grant per 2 cycles.
- Winner selection, mode=0: highest set bit of req.
- Winner selection, mode=1:
  - Search starts at index ptr-1 and descends, wrapping from 0 to N-1; the first set bit wins.
  - ptr itself is checked last.
  - With ptr=0 the search starts at N-1, so the first arbitration after reset matches fixed mode.
- ptr updates only on an accept, in either mode. Switching mode takes effect at the next IDLE arbitration and never disturbs a held grant.
- Requests are not latched:
  - A request withdrawn while another grant is held is simply not seen.
  - A request withdrawn after winning still completes its held grant. The consumer is responsible for validity.
- Single active request: that request wins in both modes, including when its index equals ptr.
- out_ready high in IDLE is ignored.
- rst asserted mid-HOLD discards the held grant, with no accept recorded, and clears ptr to 0.
- Width rules:
  - idx is zero-extended when N is not a power of 2.
  - Index arithmetic wraps modulo N, not modulo 2^IDX_W.
  - No index >= N is ever produced.

Test Plan:
- Reset and fixed mode: N=8, mode=0, rst for 2 cycles then req=8'b0010_1100, out_ready=1 → one cycle after req: out_valid=1, idx=5, onehot=8'h20, any=1; accepted at that edge; the next cycle is a bubble (out_valid=0); the following grant is idx=5 again.
- Round-robin rotation: mode=1, req=8'b1000_0101 held constant, out_ready=1 → successive grants idx=7,2,0,7,2, each separated by one bubble.
- Backpressure: mode=0, req=8'h01, out_ready=0 for 5 cycles while req changes to 8'h80 → idx stays 0 and out_valid stays 1 throughout; after out_ready=1 and the accept, the next grant is idx=7.
- Single requester and empty: mode=1, ptr=3 after a grant, req=8'b0000_1000 → idx=3. Then req=0 → out_valid stays 0, any=0, FSM stays in IDLE.
- Reset mid-operation: in HOLD with idx=6 under mode=1, assert rst for 1 cycle → out_valid=0, idx=0, onehot=0. With req=8'h41 the next grant is idx=6, confirming ptr was cleared.
- Non-power-of-2: N=5, mode=1, req=5'b10001 → grants alternate 4,0,4; idx never exceeds 4.

Source files
------------

// File: rtl/rr_priority_encoder.sv
// Registered N-input priority encoder with fixed or round-robin priority and a
// valid/ready output stage that holds each grant until the consumer accepts it.
module rr_priority_encoder #(
    parameter int N = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot,
    output logic             any
);

    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_s;
    logic             valid_r;
    logic             valid_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic [N-1:0]     onehot_r;
    logic [N-1:0]     onehot_s;
    logic [IDX_W-1:0] start_s;
    logic [IDX_W-1:0] winner_s;

    // Descending search beginning just below start, wrapping modulo N; start itself is checked last.
    function automatic logic [IDX_W-1:0] find_winner(input logic [N-1:0] r,
                                                     input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] jw;
        logic             found;
        int               j;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j  = (int'(start) + N - k) % N;
            jw = IDX_W'(j);
            if (!found && r[jw]) begin
                win   = jw;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Winner selection; a start of 0 makes the search begin at N-1, i.e. fixed priority.
    always_comb begin
        start_s  = mode ? ptr_r : {IDX_W{1'b0}};
        winner_s = find_winner(req, start_s);
    end

    // Next-state and next-output logic for the IDLE/HOLD handshake.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        valid_s  = valid_r;
        idx_s    = idx_r;
        onehot_s = onehot_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    idx_s    = winner_s;
                    onehot_s = {{(N-1){1'b0}}, 1'b1} << winner_s;
                    valid_s  = 1'b1;
                    state_s  = HOLD;
                end else begin
                    valid_s  = 1'b0;
                    onehot_s = {N{1'b0}};
                end
            end
            HOLD: begin
                // Accept: idx is deliberately kept so the consumer can still read it during the bubble.
                if (valid_r && out_ready) begin
                    valid_s  = 1'b0;
                    onehot_s = {N{1'b0}};
                    ptr_s    = idx_r;
                    state_s  = IDLE;
                end else begin
                    state_s  = HOLD;
                end
            end
            default: begin
                valid_s  = 1'b0;
                onehot_s = {N{1'b0}};
                state_s  = IDLE;
            end
        endcase
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ptr_r    <= {IDX_W{1'b0}};
            valid_r  <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
            onehot_r <= {N{1'b0}};
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            valid_r  <= valid_s;
            idx_r    <= idx_s;
            onehot_r <= onehot_s;
        end
    end

    assign out_valid = valid_r;
    assign idx       = idx_r;
    assign onehot    = onehot_r;
    assign any       = |req;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: an 8-input and a 5-input instance,
// expected grant indices queued at stimulus time and popped when the grant appears.
module tb_rr_priority_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req8;
    logic       mode8;
    logic       rdy8;
    logic       v8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic       any8;
    logic [4:0] req5;
    logic       mode5;
    logic       rdy5;
    logic       v5;
    logic [2:0] idx5;
    logic [4:0] oh5;
    logic       any5;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    rr_priority_encoder #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .req(req8), .mode(mode8), .out_ready(rdy8),
        .out_valid(v8), .idx(idx8), .onehot(oh8), .any(any8)
    );

    rr_priority_encoder #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .mode(mode5), .out_ready(rdy5),
        .out_valid(v5), .idx(idx5), .onehot(oh5), .any(any5)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant must appear one edge after the arbitrating edge; pop the queued index and compare.
    task automatic take(input string tag, input bit use5);
        int         e;
        logic [7:0] oh_e;
        step();
        chk({tag, "_valid"}, use5 ? {7'd0, v5} : {7'd0, v8}, 8'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        oh_e = (e >= 0) ? (8'd1 << e) : 8'd0;
        chk({tag, "_idx"}, use5 ? {5'd0, idx5} : {5'd0, idx8}, 8'(e));
        chk({tag, "_onehot"}, use5 ? {3'd0, oh5} : oh8, oh_e);
        if (use5) chk({tag, "_inrange"}, {7'd0, (idx5 < 3'd5)}, 8'd1);
        else      chk({tag, "_any"}, {7'd0, any8}, 8'd1);
    endtask

    task automatic bubble(input string tag, input bit use5);
        step();
        chk(tag, use5 ? {7'd0, v5} : {7'd0, v8}, 8'd0);
        chk({tag, "_oh"}, use5 ? {3'd0, oh5} : oh8, 8'd0);
    endtask

    initial begin
        rst = 1'b1; req8 = 8'd0; mode8 = 1'b0; rdy8 = 1'b0;
        req5 = 5'd0; mode5 = 1'b0; rdy5 = 1'b0;
        step(); step();
        chk("rst_valid", {7'd0, v8}, 8'd0);
        chk("rst_idx", {5'd0, idx8}, 8'd0);
        chk("rst_onehot", oh8, 8'd0);
        req8 = 8'h10; #1;
        chk("rst_any_hi", {7'd0, any8}, 8'd1);
        req8 = 8'h00; #1;
        chk("rst_any_lo", {7'd0, any8}, 8'd0);
        step();

        // Fixed priority with immediate accept and the mandatory bubble.
        rst = 1'b0; mode8 = 1'b0; req8 = 8'b0010_1100; rdy8 = 1'b1;
        exp_q.push_back(5);
        take("fix1", 1'b0);
        step();
        chk("fix_bubble", {7'd0, v8}, 8'd0);
        chk("fix_bubble_idx", {5'd0, idx8}, 8'd5);
        chk("fix_bubble_oh", oh8, 8'd0);
        exp_q.push_back(5);
        take("fix2", 1'b0);
        req8 = 8'd0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Round-robin rotation from ptr=0.
        mode8 = 1'b1; req8 = 8'b1000_0101; rdy8 = 1'b1;
        exp_q.push_back(7); exp_q.push_back(2); exp_q.push_back(0);
        exp_q.push_back(7); exp_q.push_back(2);
        for (int i = 0; i < 5; i++) begin
            take($sformatf("rr%0d", i), 1'b0);
            if (i < 4) bubble($sformatf("rr_bubble%0d", i), 1'b0);
        end
        req8 = 8'd0;
        step();

        // Backpressure: the held grant is frozen while req changes.
        mode8 = 1'b0; req8 = 8'h01; rdy8 = 1'b0;
        exp_q.push_back(0);
        take("bp_first", 1'b0);
        req8 = 8'h80;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold_v%0d", i), {7'd0, v8}, 8'd1);
            chk($sformatf("bp_hold_idx%0d", i), {5'd0, idx8}, 8'd0);
        end
        rdy8 = 1'b1;
        bubble("bp_bubble", 1'b0);
        exp_q.push_back(7);
        take("bp_next", 1'b0);

        // Single requester equal to ptr, then no requests.
        req8 = 8'b0000_1000; mode8 = 1'b0;
        step();
        exp_q.push_back(3);
        take("single_fix", 1'b0);
        mode8 = 1'b1;
        bubble("single_bubble", 1'b0);
        exp_q.push_back(3);
        take("single_rr", 1'b0);
        req8 = 8'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("empty_v%0d", i), {7'd0, v8}, 8'd0);
            chk($sformatf("empty_any%0d", i), {7'd0, any8}, 8'd0);
        end

        // Reset while holding a grant clears the pointer.
        rdy8 = 1'b0; mode8 = 1'b1; req8 = 8'h40;
        exp_q.push_back(6);
        take("mid_hold", 1'b0);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", {7'd0, v8}, 8'd0);
        chk("mid_rst_idx", {5'd0, idx8}, 8'd0);
        chk("mid_rst_onehot", oh8, 8'd0);
        rst = 1'b0; req8 = 8'h41; rdy8 = 1'b1;
        exp_q.push_back(6);
        take("mid_after", 1'b0);
        req8 = 8'd0;
        step();

        // Non-power-of-two width, round-robin wrap modulo 5.
        mode5 = 1'b1; req5 = 5'b10001; rdy5 = 1'b1;
        exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(4);
        for (int i = 0; i < 3; i++) begin
            take($sformatf("n5_%0d", i), 1'b1);
            if (i < 2) bubble($sformatf("n5_bubble%0d", i), 1'b1);
        end
        req5 = 5'd0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
